// File: rtl/fwd_scoreboard_pkg.sv
// Shared defaults and select-code encoding for the forwarding scoreboard.
package fwd_scoreboard_pkg;

  localparam int FWD_DATA_W     = 32;
  localparam int FWD_REG_AW     = 5;
  localparam int FWD_STAGES     = 3;
  localparam int FWD_NSRC       = 2;

  // Select codes: 0 picks the register-file value, FWD_SEL_STAGE0 + k picks entry k.
  localparam int FWD_SEL_ORI    = 0;
  localparam int FWD_SEL_STAGE0 = 1;

  function automatic int stage_sel(input int k);
    return FWD_SEL_STAGE0 + k;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Decode-side bus of the forwarding scoreboard: issue, flush, results, operand queries.
interface fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int NSRC   = 2,
  parameter int SEL_W  = $clog2(STAGES + 1)
);
  logic                     issue_valid;
  logic [REG_AW-1:0]        issue_dst;
  logic [STAGES-1:0]        flush_mask;
  logic [STAGES-1:0]        stage_wvalid;
  logic [STAGES*DATA_W-1:0] stage_wdata;
  logic [NSRC*REG_AW-1:0]   src_addr;
  logic [NSRC-1:0]          src_used;
  logic [NSRC*DATA_W-1:0]   src_ori;
  logic [NSRC*DATA_W-1:0]   src_fwd;
  logic [NSRC*SEL_W-1:0]    src_sel;
  logic                     stall;

  // Pipeline control side: drives issue/results/queries, consumes operands.
  modport master (
    output issue_valid, issue_dst, flush_mask, stage_wvalid, stage_wdata,
           src_addr, src_used, src_ori,
    input  src_fwd, src_sel, stall
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_dst, flush_mask, stage_wvalid, stage_wdata,
           src_addr, src_used, src_ori,
    output src_fwd, src_sel, stall
  );
endinterface

// File: rtl/fwd_scoreboard_lookup.sv
// Combinational priority match of one source operand against the in-flight entries.
module fwd_lookup
  import fwd_scoreboard_pkg::*;
#(
  parameter int DATA_W = FWD_DATA_W,
  parameter int REG_AW = FWD_REG_AW,
  parameter int STAGES = FWD_STAGES,
  parameter int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic [STAGES-1:0]             ent_vld,
  input  logic [STAGES-1:0]             ent_rdy,
  input  logic [STAGES-1:0][REG_AW-1:0] ent_dst,
  input  logic [STAGES-1:0][DATA_W-1:0] ent_data,
  input  logic [STAGES-1:0]             stage_wvalid,
  input  logic [STAGES-1:0][DATA_W-1:0] stage_wdata,
  input  logic [REG_AW-1:0]             addr,
  input  logic [DATA_W-1:0]             ori,
  output logic [DATA_W-1:0]             fwd,
  output logic [SEL_W-1:0]              sel,
  output logic                          pend
);

  // Walk oldest to youngest so the youngest matching producer overwrites older ones.
  always_comb begin
    fwd  = ori;
    sel  = SEL_W'(FWD_SEL_ORI);
    pend = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (ent_vld[k] && (ent_dst[k] == addr) && (addr != '0)) begin
        sel = SEL_W'(stage_sel(k));
        if (ent_rdy[k] || stage_wvalid[k]) begin
          fwd  = ent_rdy[k] ? ent_data[k] : stage_wdata[k];
          pend = 1'b0;
        end else begin
          fwd  = ori;
          pend = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writes, forwards operands, raises stall.
// Optional statistics counters are enabled by defining FWD_SCOREBOARD_STAT_EN.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DATA_W = FWD_DATA_W,
  parameter int REG_AW = FWD_REG_AW,
  parameter int STAGES = FWD_STAGES,
  parameter int NSRC   = FWD_NSRC,
  parameter int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FWD_SCOREBOARD_STAT_EN
  output logic [31:0]       stat_stall_cnt,
  output logic [31:0]       stat_fwd_cnt,
`endif
  fwd_scoreboard_if.slave   bus
);

  logic [STAGES-1:0]             ent_vld;
  logic [STAGES-1:0]             ent_rdy;
  logic [STAGES-1:0][REG_AW-1:0] ent_dst;
  logic [STAGES-1:0][DATA_W-1:0] ent_data;
  logic [STAGES-1:0][DATA_W-1:0] wdata;
  logic [NSRC-1:0]               pend;
  logic [NSRC-1:0]               sel_nz;
  logic [NSRC*DATA_W-1:0]        fwd_raw;
  logic [NSRC*SEL_W-1:0]         sel_raw;
  logic                          stall_raw;

  assign wdata = bus.stage_wdata;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_lookup #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .STAGES (STAGES),
      .SEL_W  (SEL_W)
    ) u_lookup (
      .ent_vld      (ent_vld),
      .ent_rdy      (ent_rdy),
      .ent_dst      (ent_dst),
      .ent_data     (ent_data),
      .stage_wvalid (bus.stage_wvalid),
      .stage_wdata  (wdata),
      .addr         (bus.src_addr[i*REG_AW +: REG_AW]),
      .ori          (bus.src_ori[i*DATA_W +: DATA_W]),
      .fwd          (fwd_raw[i*DATA_W +: DATA_W]),
      .sel          (sel_raw[i*SEL_W +: SEL_W]),
      .pend         (pend[i])
    );
    assign sel_nz[i] = (sel_raw[i*SEL_W +: SEL_W] != SEL_W'(FWD_SEL_ORI));
  end

  assign stall_raw = |(pend & bus.src_used);

  // While reset is held the entry array may be stale, so outputs fall back to pass-through.
  always_comb begin
    bus.stall   = stall_raw & ~reset;
    bus.src_sel = reset ? '0 : sel_raw;
    bus.src_fwd = reset ? bus.src_ori : fwd_raw;
  end

  // Shift entries down one stage each edge, capturing results and applying flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_vld  <= '0;
      ent_rdy  <= '0;
      ent_dst  <= '0;
      ent_data <= '0;
    end else begin
      ent_vld[0]  <= bus.issue_valid & ~stall_raw & ~(|bus.flush_mask);
      ent_dst[0]  <= bus.issue_dst;
      ent_rdy[0]  <= 1'b0;
      ent_data[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        ent_vld[k] <= ent_vld[k-1] & ~bus.flush_mask[k-1];
        ent_dst[k] <= ent_dst[k-1];
        if (!ent_rdy[k-1] && bus.stage_wvalid[k-1]) begin
          ent_rdy[k]  <= 1'b1;
          ent_data[k] <= wdata[k-1];
        end else begin
          ent_rdy[k]  <= ent_rdy[k-1];
          ent_data[k] <= ent_data[k-1];
        end
      end
    end
  end

`ifdef FWD_SCOREBOARD_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count stall cycles and cycles where a used operand was actually forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
    end else begin
      if (stall_raw) stat_stall_cnt <= sat_inc(stat_stall_cnt);
      if (|(bus.src_used & sel_nz & ~pend)) stat_fwd_cnt <= sat_inc(stat_fwd_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (default parameters: 32-bit data, 3 stages, 2 sources).
module tb_fwd_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ST = 3;
  localparam int NS = 2;
  localparam int SW = 2;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fwd_scoreboard_if #(.DATA_W(DW), .REG_AW(AW), .STAGES(ST), .NSRC(NS), .SEL_W(SW)) bus ();

`ifdef FWD_SCOREBOARD_STAT_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_fwd_cnt;
`endif

  fwd_scoreboard #(.DATA_W(DW), .REG_AW(AW), .STAGES(ST), .NSRC(NS), .SEL_W(SW)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef FWD_SCOREBOARD_STAT_EN
    .stat_stall_cnt (stat_stall_cnt),
    .stat_fwd_cnt   (stat_fwd_cnt),
`endif
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input int i);
    return bus.src_fwd[i*DW +: DW];
  endfunction

  function automatic logic [SW-1:0] sel(input int i);
    return bus.src_sel[i*SW +: SW];
  endfunction

  task automatic idle();
    bus.issue_valid  = 1'b0;
    bus.issue_dst    = '0;
    bus.flush_mask   = '0;
    bus.stage_wvalid = '0;
    bus.stage_wdata  = '0;
    bus.src_addr     = '0;
    bus.src_used     = '0;
    bus.src_ori      = {32'h0000_BBBB, 32'h0000_AAAA};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] dst);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_dst   = dst;
    tick();
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < ST; n++) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_sel0", sel(0), 2'd0);
    chk("rst_fwd0", fwd(0), 32'h0000_AAAA);
    reset = 1'b0;

    // 1: same-cycle bypass, then captured value one stage later
    issue(5'd8);
    idle();
    bus.stage_wvalid = 3'b001;
    bus.stage_wdata[31:0] = 32'h1234;
    bus.src_addr[4:0] = 5'd8;
    bus.src_used = 2'b01;
    #1;
    chk("t1_bypass_fwd", fwd(0), 32'h1234);
    chk("t1_bypass_sel", sel(0), 2'd1);
    chk("t1_bypass_stall", bus.stall, 1'b0);
    tick();
    idle();
    bus.src_addr[4:0] = 5'd8;
    bus.src_used = 2'b01;
    #1;
    chk("t1_capt_fwd", fwd(0), 32'h1234);
    chk("t1_capt_sel", sel(0), 2'd2);
    chk("t1_capt_stall", bus.stall, 1'b0);
    chk("t1_src1_sel", sel(1), 2'd0);
    chk("t1_src1_fwd", fwd(1), 32'h0000_BBBB);
    bus.stage_wvalid = 3'b010;
    bus.stage_wdata[63:32] = 32'h9999;
    #1;
    chk("t1_frozen_fwd", fwd(0), 32'h1234);
    drain();

    // 2: load-use stall, bubble insertion, late result, drop from last stage
    issue(5'd9);
    idle();
    bus.src_addr[4:0] = 5'd9;
    bus.src_used = 2'b01;
    bus.issue_valid = 1'b1;
    bus.issue_dst = 5'd12;
    #1;
    chk("t2_stall", bus.stall, 1'b1);
    chk("t2_stall_sel", sel(0), 2'd1);
    chk("t2_stall_fwd", fwd(0), 32'h0000_AAAA);
    tick();
    idle();
    bus.src_addr = {5'd12, 5'd9};
    bus.src_used = 2'b01;
    bus.stage_wvalid = 3'b010;
    bus.stage_wdata[63:32] = 32'hBEEF;
    #1;
    chk("t2_late_stall", bus.stall, 1'b0);
    chk("t2_late_fwd", fwd(0), 32'hBEEF);
    chk("t2_late_sel", sel(0), 2'd2);
    chk("t2_bubble_sel", sel(1), 2'd0);
    tick();
    idle();
    bus.src_addr[4:0] = 5'd9;
    bus.src_used = 2'b01;
    #1;
    chk("t2_last_sel", sel(0), 2'd3);
    chk("t2_last_fwd", fwd(0), 32'hBEEF);
    tick();
    idle();
    bus.src_addr[4:0] = 5'd9;
    #1;
    chk("t2_gone_sel", sel(0), 2'd0);
    chk("t2_gone_fwd", fwd(0), 32'h0000_AAAA);
    drain();

    // 3: duplicate destination, youngest wins; register 0 never matches
    issue(5'd5);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_dst = 5'd5;
    bus.stage_wvalid = 3'b001;
    bus.stage_wdata[31:0] = 32'h1;
    tick();
    idle();
    bus.stage_wvalid = 3'b001;
    bus.stage_wdata[31:0] = 32'h2;
    bus.src_addr[4:0] = 5'd5;
    bus.issue_valid = 1'b1;
    bus.issue_dst = 5'd0;
    #1;
    chk("t3_young_fwd", fwd(0), 32'h2);
    chk("t3_young_sel", sel(0), 2'd1);
    tick();
    idle();
    bus.src_addr = {5'd0, 5'd5};
    #1;
    chk("t3_capt_fwd", fwd(0), 32'h2);
    chk("t3_capt_sel", sel(0), 2'd2);
    chk("t3_r0_sel", sel(1), 2'd0);
    chk("t3_r0_fwd", fwd(1), 32'h0000_BBBB);
    drain();

    // 4: pending producer but operand unused
    issue(5'd7);
    idle();
    bus.src_addr[4:0] = 5'd7;
    #1;
    chk("t4_unused_stall", bus.stall, 1'b0);
    chk("t4_unused_sel", sel(0), 2'd1);
    chk("t4_unused_fwd", fwd(0), 32'h0000_AAAA);
    bus.src_used = 2'b01;
    #1;
    chk("t4_used_stall", bus.stall, 1'b1);
    drain();

    // 5: flush of the stalling producer; flush also kills a plain issue
    issue(5'd3);
    idle();
    bus.src_addr[4:0] = 5'd3;
    bus.src_used = 2'b01;
    bus.flush_mask = 3'b001;
    #1;
    chk("t5_flush_stall", bus.stall, 1'b1);
    chk("t5_flush_sel", sel(0), 2'd1);
    tick();
    idle();
    bus.src_addr[4:0] = 5'd3;
    bus.src_used = 2'b01;
    #1;
    chk("t5_after_stall", bus.stall, 1'b0);
    chk("t5_after_sel", sel(0), 2'd0);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_dst = 5'd6;
    bus.flush_mask = 3'b100;
    tick();
    idle();
    bus.src_addr[4:0] = 5'd6;
    #1;
    chk("t5_killed_issue_sel", sel(0), 2'd0);
    drain();

    // 6: reset in the middle of operation
    issue(5'd10);
    issue(5'd11);
    idle();
    bus.src_addr = {5'd11, 5'd10};
    #1;
    chk("t6_pre_sel0", sel(0), 2'd2);
    chk("t6_pre_sel1", sel(1), 2'd1);
    reset = 1'b1;
    bus.src_used = 2'b11;
    #1;
    chk("t6_in_rst_stall", bus.stall, 1'b0);
    chk("t6_in_rst_sel0", sel(0), 2'd0);
    chk("t6_in_rst_fwd1", fwd(1), 32'h0000_BBBB);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_post_sel0", sel(0), 2'd0);
    chk("t6_post_sel1", sel(1), 2'd0);
    chk("t6_post_stall", bus.stall, 1'b0);
`ifdef FWD_SCOREBOARD_STAT_EN
    chk("t6_stat_stall", stat_stall_cnt, 32'd0);
    chk("t6_stat_fwd", stat_fwd_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
